// File: rtl/shift_result_fifo_if.sv
// Handshake bundle between the shifter, the result FIFO and its consumer.
// The FIFO connects through the slave modport. The bench drives the master side.
interface shift_result_fifo_if #(
    parameter int DW = 5
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_shift;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_shift;

    modport master (
        output in_valid, in_data, in_shift, out_ready,
        input  in_ready, out_valid, out_data, out_shift
    );

    modport slave (
        input  in_valid, in_data, in_shift, out_ready,
        output in_ready, out_valid, out_data, out_shift
    );
endinterface

// File: rtl/shift_result_fifo.sv
// First-word-fall-through FIFO for shifter results.
// It keeps a saturating count of accepted shifted words that have the MSB set.
module shift_result_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 5,
    parameter int CW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    shift_result_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CW-1:0]              carry_cnt
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    // Each entry stores {shift flag, data}.
    logic [DW:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CW-1:0]   carry_q, carry_d;
    logic            push, pop;
    logic            in_ready, out_valid;

    // Ready comes only from registered occupancy. A pop on a full cycle
    // frees a slot only from the following cycle.
    assign in_ready  = (count_q != CNTW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        carry_d  = carry_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            carry_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
            if (push && bus.in_shift && bus.in_data[DW-1] && (carry_q != '1))
                carry_d = carry_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            carry_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            if (push && !flush) mem_q[wr_ptr_q] <= {bus.in_shift, bus.in_data};
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = mem_q[rd_ptr_q][DW-1:0];
    assign bus.out_shift = mem_q[rd_ptr_q][DW];
    assign count         = count_q;
    assign carry_cnt     = carry_q;
endmodule

// File: tb/tb_shift_result_fifo.sv
// Directed test of shift_result_fifo. Each expected value is worked out by hand.
module tb_shift_result_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] count;
    logic [7:0] carry_cnt;
    int         n_chk = 0;
    int         n_err = 0;

    shift_result_fifo_if #(.DW(5)) bus ();

    shift_result_fifo #(.DEPTH(4), .DW(5), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus.slave),
        .count     (count),
        .carry_cnt (carry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] d, input logic s, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_shift  = s;
        bus.out_ready = r;
    endtask

    initial begin
        logic [4:0] seq [4];
        seq[0] = 5'h03; seq[1] = 5'h06; seq[2] = 5'h0C; seq[3] = 5'h18;
        drive(1'b0, 5'h00, 1'b0, 1'b0);

        // Reset state
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_carry", 32'(carry_cnt), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_shift", 32'(bus.out_shift), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single push. The word is visible one cycle later.
        drive(1'b1, 5'b10110, 1'b1, 1'b0);
        tick();
        drive(1'b0, 5'h00, 1'b0, 1'b0);
        chk("one_out_valid", 32'(bus.out_valid), 32'd1);
        chk("one_out_data", 32'(bus.out_data), 32'h16);
        chk("one_out_shift", 32'(bus.out_shift), 32'd1);
        chk("one_count", 32'(count), 32'd1);
        chk("one_carry", 32'(carry_cnt), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("one_pop_count", 32'(count), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_carry", 32'(carry_cnt), 32'd0);

        // Fill the FIFO, then try a fifth push, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[i], 1'b1, 1'b0);
            tick();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 5'h1F, 1'b1, 1'b0);
        tick();
        chk("fifth_count", 32'(count), 32'd4);
        chk("fifth_carry", 32'(carry_cnt), 32'd1);
        drive(1'b0, 5'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_data%0d", i), 32'(bus.out_data), 32'(seq[i]));
            chk($sformatf("drain_shift%0d", i), 32'(bus.out_shift), 32'd1);
            tick();
        end
        bus.out_ready = 1'b0;
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_carry", 32'(carry_cnt), 32'd1);

        // When the FIFO is full, a push and a pop together: only the pop happens.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 5'h0A, 1'b0, 1'b1);
        chk("full_head", 32'(bus.out_data), 32'h01);
        tick();
        chk("full_pop_count", 32'(count), 32'd3);
        chk("full_pop_in_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 5'h0A, 1'b0, 1'b0);
        tick();
        chk("full_repush_count", 32'(count), 32'd4);
        drive(1'b0, 5'h00, 1'b0, 1'b1);
        chk("full_order0", 32'(bus.out_data), 32'h02); tick();
        chk("full_order1", 32'(bus.out_data), 32'h03); tick();
        chk("full_order2", 32'(bus.out_data), 32'h04); tick();
        chk("full_order3", 32'(bus.out_data), 32'h0A); tick();
        chk("full_empty", 32'(count), 32'd0);

        // Steady state at count=2 across pointer wrap
        drive(1'b1, 5'h11, 1'b0, 1'b0); tick();
        drive(1'b1, 5'h12, 1'b0, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(8'h13 + i), 1'b0, 1'b1);
            chk($sformatf("steady_data%0d", i), 32'(bus.out_data), 32'h11 + 32'(i));
            tick();
            chk($sformatf("steady_count%0d", i), 32'(count), 32'd2);
        end
        drive(1'b0, 5'h00, 1'b0, 1'b1);
        chk("steady_tail0", 32'(bus.out_data), 32'h1B); tick();
        chk("steady_tail1", 32'(bus.out_data), 32'h1C); tick();
        chk("steady_empty", 32'(count), 32'd0);
        chk("steady_carry", 32'(carry_cnt), 32'd1);

        // Carry counter saturates and does not wrap.
        bus.out_ready = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            drive(1'b1, 5'h10, 1'b1, 1'b1);
            tick();
            if (i == 254) chk("sat_254", 32'(carry_cnt), 32'd254);
            if (i == 255) chk("sat_255", 32'(carry_cnt), 32'd255);
        end
        chk("sat_300", 32'(carry_cnt), 32'd255);
        chk("sat_count", 32'(count), 32'd1);
        drive(1'b0, 5'h00, 1'b0, 1'b1); tick();
        flush = 1'b1; tick(); flush = 1'b0;
        drive(1'b1, 5'h10, 1'b0, 1'b1); tick();
        drive(1'b1, 5'h1F, 1'b0, 1'b1); tick();
        drive(1'b0, 5'h00, 1'b0, 1'b1); tick();
        chk("noshift_carry", 32'(carry_cnt), 32'd0);

        // A flush discards the push and the pop in the same cycle.
        for (int i = 5; i <= 7; i++) begin
            drive(1'b1, 5'(i), 1'b0, 1'b0);
            tick();
        end
        chk("preflush_count", 32'(count), 32'd3);
        drive(1'b1, 5'h1E, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 5'h00, 1'b0, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_carry2", 32'(carry_cnt), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);

        // Assert reset asynchronously in the middle of a burst.
        drive(1'b1, 5'h19, 1'b1, 1'b0); tick();
        drive(1'b1, 5'h1A, 1'b1, 1'b0); tick();
        chk("burst_count", 32'(count), 32'd2);
        chk("burst_carry", 32'(carry_cnt), 32'd2);
        chk("burst_head", 32'(bus.out_data), 32'h19);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_carry", 32'(carry_cnt), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_out_data", 32'(bus.out_data), 32'd0);
        chk("arst_out_shift", 32'(bus.out_shift), 32'd0);
        tick();
        chk("arst_hold_count", 32'(count), 32'd0);
        drive(1'b0, 5'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
